mux_arbiter_2to1: RTL and testbench

Arbiter and sequencer for the shared 2-to-1 data multiplexer that merges two producer ports (X, Y) onto one downstream bus.
- Owns the mux select line and arbitrates round-robin between the two requesters.
- Holds ownership for a bounded burst of beats, so a single producer cannot starve the other.
- Sits between the two datapath producers and the consumer.

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux_arbiter_2to1_mux.sv | 15 +
 rtl/mux_arbiter_2to1.sv | 142 ++++++++++++++
 tb/tb_mux_arbiter_2to1.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2-to-1 mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_X = 2'd1,
    ARB_OWN_Y = 2'd2
  } arb_state_e;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  // Burst counter width: max(1, clog2(burst_len)).
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/mux_arbiter_2to1_mux.sv
// Width-generic 2-to-1 data mux cell; the select comes from the arbiter's register.
module mux_arbiter_2to1_mux #(
  parameter int unsigned Width = 4
) (
  input  logic             sel_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] y_o
);

  always_comb begin
    y_o = sel_i ? b_i : a_i;
  end

endmodule

// File: rtl/mux_arbiter_2to1.sv
// Round-robin burst arbiter driving the select of a shared 2-to-1 data mux.
// Optional tenure statistics are built when MUX_ARB_STATS_EN is defined.
module mux_arbiter_2to1
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_x,
  input  logic [DATA_W-1:0] data_x,
  output logic              ack_x,
  input  logic              req_y,
  input  logic [DATA_W-1:0] data_y,
  output logic              ack_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef MUX_ARB_STATS_EN
  output logic [7:0]        stat_grants_x,
  output logic [7:0]        stat_grants_y,
`endif
  output logic              select,
  output logic              grant_x,
  output logic              grant_y
);

  localparam int unsigned    CntW    = cnt_width(BURST_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(BURST_LEN - 1);

  arb_state_e      state_q, state_d;
  logic            select_q, grant_x_q, grant_y_q, last_owner_q;
  logic [CntW-1:0] beat_cnt_q;

  logic own_x, own_y, beat, rel, owner_req, other_req;
  logic start_x, start_y;

  always_comb begin
    own_x     = (state_q == ARB_OWN_X);
    own_y     = (state_q == ARB_OWN_Y);
    out_valid = (own_x & req_x) | (own_y & req_y);
    ack_x     = own_x & req_x & out_ready;
    ack_y     = own_y & req_y & out_ready;
    beat      = ack_x | ack_y;
    owner_req = own_x ? req_x : req_y;
    other_req = own_x ? req_y : req_x;
  end

  always_comb begin
    state_d = state_q;
    rel     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Ties go to whichever side did not own the bus last.
        if (req_x && (!req_y || last_owner_q == SEL_Y)) begin
          state_d = ARB_OWN_X;
        end else if (req_y) begin
          state_d = ARB_OWN_Y;
        end
      end
      ARB_OWN_X, ARB_OWN_Y: begin
        rel = !owner_req || (beat && beat_cnt_q == CntLast);
        if (rel) begin
          if (other_req) begin
            state_d = own_x ? ARB_OWN_Y : ARB_OWN_X;
          end else if (owner_req) begin
            state_d = state_q;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // A tenure starts on entry to an owned state or on a self-renewal after release.
    start_x = (state_d == ARB_OWN_X) && (state_q != ARB_OWN_X || rel);
    start_y = (state_d == ARB_OWN_Y) && (state_q != ARB_OWN_Y || rel);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      select_q     <= SEL_X;
      grant_x_q    <= 1'b0;
      grant_y_q    <= 1'b0;
      beat_cnt_q   <= '0;
      last_owner_q <= SEL_Y;
    end else begin
      state_q <= state_d;
      if (start_x) begin
        select_q  <= SEL_X;
        grant_x_q <= 1'b1;
        grant_y_q <= 1'b0;
      end else if (start_y) begin
        select_q  <= SEL_Y;
        grant_x_q <= 1'b0;
        grant_y_q <= 1'b1;
      end else if (state_d == ARB_IDLE) begin
        grant_x_q <= 1'b0;
        grant_y_q <= 1'b0;
      end
      if (rel) begin
        beat_cnt_q   <= '0;
        last_owner_q <= own_x ? SEL_X : SEL_Y;
      end else if (beat) begin
        beat_cnt_q <= beat_cnt_q + CntW'(1);
      end
    end
  end

  assign select  = select_q;
  assign grant_x = grant_x_q;
  assign grant_y = grant_y_q;

`ifdef MUX_ARB_STATS_EN
  logic [7:0] stat_x_q, stat_y_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_x_q <= '0;
      stat_y_q <= '0;
    end else begin
      if (start_x && stat_x_q != 8'hff) stat_x_q <= stat_x_q + 8'd1;
      if (start_y && stat_y_q != 8'hff) stat_y_q <= stat_y_q + 8'd1;
    end
  end

  assign stat_grants_x = stat_x_q;
  assign stat_grants_y = stat_y_q;
`endif

  mux_arbiter_2to1_mux #(
    .Width (DATA_W)
  ) u_data_mux (
    .sel_i (select_q),
    .a_i   (data_x),
    .b_i   (data_y),
    .y_o   (out_data)
  );

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Directed bench for mux_arbiter_2to1 (BURST_LEN 4 and 1); stats checks when MUX_ARB_STATS_EN.
module tb_mux_arbiter_2to1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_x, req_y, out_ready;
  logic [3:0] data_x, data_y;

  logic       ack_x, ack_y, out_valid, select, grant_x, grant_y;
  logic [3:0] out_data;
  logic       ack_x1, ack_y1, out_valid1, select1, grant_x1, grant_y1;
  logic [3:0] out_data1;
`ifdef MUX_ARB_STATS_EN
  logic [7:0] stat_x, stat_y, stat_x1, stat_y1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter_2to1 #(.DATA_W(4), .BURST_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_x(req_x), .data_x(data_x), .ack_x(ack_x),
    .req_y(req_y), .data_y(data_y), .ack_y(ack_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MUX_ARB_STATS_EN
    .stat_grants_x(stat_x), .stat_grants_y(stat_y),
`endif
    .select(select), .grant_x(grant_x), .grant_y(grant_y)
  );

  mux_arbiter_2to1 #(.DATA_W(4), .BURST_LEN(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_x(req_x), .data_x(data_x), .ack_x(ack_x1),
    .req_y(req_y), .data_y(data_y), .ack_y(ack_y1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
`ifdef MUX_ARB_STATS_EN
    .stat_grants_x(stat_x1), .stat_grants_y(stat_y1),
`endif
    .select(select1), .grant_x(grant_x1), .grant_y(grant_y1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_own(input string tag, input logic sel, input logic acked);
    check({tag, " select"}, 32'(select), 32'(sel));
    check({tag, " grant_x"}, 32'(grant_x), 32'(!sel));
    check({tag, " grant_y"}, 32'(grant_y), 32'(sel));
    check({tag, " ack_x"}, 32'(ack_x), 32'(acked && !sel));
    check({tag, " ack_y"}, 32'(ack_y), 32'(acked && sel));
  endtask

  initial begin
    // Reset with both requesting; combinational outputs stay low in IDLE.
    reset_n = 1'b0; req_x = 1'b1; req_y = 1'b1; out_ready = 1'b1;
    data_x = 4'h3; data_y = 4'hC;
    #3;
    check("rst select", 32'(select), 32'd0);
    check("rst grant_x", 32'(grant_x), 32'd0);
    check("rst grant_y", 32'(grant_y), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst ack_x", 32'(ack_x), 32'd0);
    check("rst ack_y", 32'(ack_y), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Contention: 4 X beats then 4 Y beats alternating; BURST_LEN 1 toggles each beat.
    for (int i = 0; i < 12; i++) begin
      tick();
      check_own($sformatf("alt%0d", i), 1'((i / 4) % 2), 1'b1);
      check($sformatf("alt%0d data", i), 32'(out_data), ((i / 4) % 2) ? 32'hC : 32'h3);
      check($sformatf("bl1 %0d select", i), 32'(select1), 32'(i % 2));
      check($sformatf("bl1 %0d ack_x", i), 32'(ack_x1), 32'((i % 2) == 0));
      check($sformatf("bl1 %0d ack_y", i), 32'(ack_y1), 32'((i % 2) == 1));
    end

    // Only Y requests: one-cycle grant latency, back-to-back tenures without a bubble.
    reset_n = 1'b0;
    #1;
    req_x = 1'b0; req_y = 1'b0;
    reset_n = 1'b1;
    tick();
    check("idle out_valid", 32'(out_valid), 32'd0);
    req_y = 1'b1; data_y = 4'hA;
    #1;
    check("y latency grant_y", 32'(grant_y), 32'd0);
    check("y latency ack_y", 32'(ack_y), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_own($sformatf("y%0d", i), 1'b1, 1'b1);
      check($sformatf("y%0d data", i), 32'(out_data), 32'hA);
    end
    tick();
    req_y = 1'b0;
    #1;
    check("y drop out_valid", 32'(out_valid), 32'd0);
    tick();
    check("y idle grant_y", 32'(grant_y), 32'd0);
    check("y idle select hold", 32'(select), 32'd1);
    check("y idle out_valid", 32'(out_valid), 32'd0);

    // Stall in OWN_X at beat_cnt 2: owner holds and finishes its burst after the stall.
    reset_n = 1'b0;
    #1;
    req_x = 1'b1; req_y = 1'b1; out_ready = 1'b1; data_x = 4'h5;
    reset_n = 1'b1;
    tick();
    check_own("st b0", 1'b0, 1'b1);
    tick();
    check_own("st b1", 1'b0, 1'b1);
    tick();
    out_ready = 1'b0;
    #1;
    check_own("stall0", 1'b0, 1'b0);
    check("stall0 out_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_own($sformatf("stall%0d", i), 1'b0, 1'b0);
    end
    tick();
    out_ready = 1'b1;
    #1;
    check_own("st b2", 1'b0, 1'b1);
    tick();
    check_own("st b3", 1'b0, 1'b1);
    tick();
    check_own("st y b0", 1'b1, 1'b1);
    tick();
    check_own("st y b1", 1'b1, 1'b1);
    tick();
    // Reset mid-burst (Y at beat_cnt 2): immediate return to reset values.
    reset_n = 1'b0;
    #1;
    check("mid rst grant_y", 32'(grant_y), 32'd0);
    check("mid rst select", 32'(select), 32'd0);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst ack_y", 32'(ack_y), 32'd0);
    reset_n = 1'b1;
    tick();
    check_own("post rst tie", 1'b0, 1'b1);

    // After X releases to IDLE, a tie goes to Y.
    reset_n = 1'b0;
    #1;
    req_x = 1'b1; req_y = 1'b0;
    reset_n = 1'b1;
    tick();
    check_own("solo x", 1'b0, 1'b1);
    req_x = 1'b0;
    tick();
    check("x idle grant_x", 32'(grant_x), 32'd0);
    req_x = 1'b1; req_y = 1'b1;
    tick();
    check_own("tie after x", 1'b1, 1'b1);

`ifdef MUX_ARB_STATS_EN
    // 300 X tenures saturate the X counter.
    reset_n = 1'b0;
    #1;
    req_x = 1'b1; req_y = 1'b0; out_ready = 1'b1;
    reset_n = 1'b1;
    check("stat rst", 32'(stat_x), 32'd0);
    tick();
    check("stat first", 32'(stat_x), 32'd1);
    repeat (300 * 4) tick();
    check("stat sat x", 32'(stat_x), 32'd255);
    check("stat y", 32'(stat_y), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
